tone_sequencer: RTL and testbench



---
 rtl/audio_pkg.sv | 25 ++
 rtl/tri_dds.sv | 40 ++++
 rtl/tone_sequencer.sv | 148 ++++++++++++++
 tb/tb_tone_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the jingle player: FSM states, silence level,
// DDS start phase and the tone increment table.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int CLK_HZ = 25000000;

    localparam logic [7:0]  SILENCE     = 8'h80;
    localparam logic [23:0] PHASE_START = 24'h400000;

    // Phase increment for a tone of freq_hz: round(freq_hz * 2^24 / CLK_HZ).
    function automatic logic [23:0] inc_of(input int freq_hz);
        longint scaled;
        scaled = (longint'(freq_hz) * 64'sd16777216 + longint'(CLK_HZ / 2)) / longint'(CLK_HZ);
        return 24'(scaled);
    endfunction

    localparam logic [23:0] INC [0:3] = '{inc_of(1000), inc_of(1250), inc_of(1500), inc_of(2000)};

endpackage

// File: rtl/tri_dds.sv
// DDS phase accumulator with triangle shaping and power-of-two volume attenuation.
// SAMPLE is combinational from the current (pre-increment) phase.
module tri_dds
    import audio_pkg::*;
#(
    parameter int PHASE_W = 24
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               LOAD,
    input  logic               EN,
    input  logic [PHASE_W-1:0] INC,
    input  logic [1:0]         VOL,
    output logic [7:0]         SAMPLE
);

    logic [PHASE_W-1:0] phase_reg;
    logic [7:0]         tri_val;
    logic signed [8:0]  centred;
    logic signed [8:0]  scaled;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_reg <= '0;
        end else if (LOAD) begin
            phase_reg <= PHASE_W'(PHASE_START);
        end else if (EN) begin
            phase_reg <= phase_reg + INC;
        end
    end

    // Top bit selects the falling half, so one phase wrap is one 0->255->0 period.
    always_comb begin
        tri_val = phase_reg[PHASE_W-1] ? ~phase_reg[PHASE_W-2 -: 8] : phase_reg[PHASE_W-2 -: 8];
        centred = $signed({1'b0, tri_val}) - 9'sd128;
        scaled  = centred >>> VOL;
        SAMPLE  = 8'(scaled + 9'sd128);
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays a fixed sequence of triangle tones through tri_dds with silent gaps,
// reporting BUSY while active and a one-cycle DONE on normal completion.
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int TONE_CYCLES = 6250000,
    parameter int GAP_CYCLES  = 1250000,
    parameter int NUM_TONES   = 3,
    parameter int PHASE_W     = 24
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic       STOP,
    input  logic [1:0] VOL,
    output logic [7:0] SOUND,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] TONE_IDX
);

    localparam int MAX_CYCLES = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       LAST_TONE = 2'(NUM_TONES - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [1:0]         tone_idx_reg, tone_idx_next;
    logic [7:0]         sound_reg, sound_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               dds_load;
    logic               dds_en;
    logic [7:0]         dds_sample;
    logic [PHASE_W-1:0] inc_table [0:3];
    logic [PHASE_W-1:0] dds_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_inc
            assign inc_table[gi] = PHASE_W'(INC[gi]);
        end
    endgenerate

    assign dds_inc = inc_table[tone_idx_reg];

    tri_dds #(
        .PHASE_W (PHASE_W)
    ) u_dds (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .LOAD    (dds_load),
        .EN      (dds_en),
        .INC     (dds_inc),
        .VOL     (VOL),
        .SAMPLE  (dds_sample)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            tone_idx_reg <= 2'd0;
            sound_reg    <= SILENCE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            tone_idx_reg <= tone_idx_next;
            sound_reg    <= sound_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        tone_idx_next = tone_idx_reg;
        sound_next    = sound_reg;
        done_next     = 1'b0;
        dds_load      = 1'b0;
        dds_en        = 1'b0;

        if (STOP) begin
            state_next = IDLE;
            sound_next = SILENCE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    sound_next = SILENCE;
                    if (START) begin
                        state_next    = PLAY;
                        tone_idx_next = 2'd0;
                        count_next    = TONE_LAST;
                        dds_load      = 1'b1;
                    end
                end
                PLAY: begin
                    // The final cycle of a tone is silent so every tone ends on the centre level.
                    if (count_reg == '0) begin
                        sound_next = SILENCE;
                        if (tone_idx_reg == LAST_TONE) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = GAP;
                            count_next = GAP_LAST;
                        end
                    end else begin
                        sound_next = dds_sample;
                        dds_en     = 1'b1;
                        count_next = count_reg - CNT_ONE;
                    end
                end
                GAP: begin
                    sound_next = SILENCE;
                    if (count_reg == '0) begin
                        state_next    = PLAY;
                        tone_idx_next = tone_idx_reg + 2'd1;
                        count_next    = TONE_LAST;
                        dds_load      = 1'b1;
                    end else begin
                        count_next = count_reg - CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    sound_next = SILENCE;
                end
            endcase
        end

        busy_next = (state_next != IDLE);
    end

    assign SOUND    = sound_reg;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;
    assign TONE_IDX = tone_idx_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench: a timeline model predicts every output cycle of two sequencer
// instances (short 3-tone jingle, long single tone) and a monitor compares them.
module tb_tone_sequencer;

    localparam longint PHASE_MOD   = 64'd16777216;
    localparam longint PHASE_START = 64'd4194304;   // quarter turn: triangle at mid level
    localparam int     TC0 = 64;
    localparam int     GC0 = 8;
    localparam int     NT0 = 3;
    localparam int     TC1 = 25100;
    localparam int     GC1 = 8;
    localparam int     NT1 = 1;
    localparam int     JINGLE0 = NT0 * TC0 + (NT0 - 1) * GC0;

    typedef struct packed {
        logic [7:0] sound;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start0 = 1'b0, stop0 = 1'b0;
    logic       start1 = 1'b0, stop1 = 1'b0;
    logic [1:0] vol0 = 2'd0, vol1 = 2'd0;
    logic [7:0] sound0, sound1;
    logic       busy0, busy1, done0, done1;
    logic [1:0] idx0, idx1;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int n_cmp = 0;
    int n_fail = 0;
    int n_done0 = 0;

    bit         playing [2];
    int         kpos [2];
    logic [1:0] last_idx [2];

    always #5 clk = ~clk;

    tone_sequencer #(
        .TONE_CYCLES (TC0), .GAP_CYCLES (GC0), .NUM_TONES (NT0), .PHASE_W (24)
    ) u_dut (
        .CLK (clk), .RESET_N (rst_n), .START (start0), .STOP (stop0), .VOL (vol0),
        .SOUND (sound0), .BUSY (busy0), .DONE (done0), .TONE_IDX (idx0)
    );

    tone_sequencer #(
        .TONE_CYCLES (TC1), .GAP_CYCLES (GC1), .NUM_TONES (NT1), .PHASE_W (24)
    ) u_long (
        .CLK (clk), .RESET_N (rst_n), .START (start1), .STOP (stop1), .VOL (vol1),
        .SOUND (sound1), .BUSY (busy1), .DONE (done1), .TONE_IDX (idx1)
    );

    function automatic int tone_inc(input int idx);
        int freqs [4];
        freqs = '{1000, 1250, 1500, 2000};
        return int'((longint'(freqs[idx]) * PHASE_MOD + 64'd12500000) / 64'd25000000);
    endfunction

    // Triangle level from the phase, centred on 128, then attenuated by 2^vol.
    function automatic logic [7:0] shape(input longint ph_in, input int v);
        longint ph;
        int top, tv, s;
        ph  = ph_in % PHASE_MOD;
        top = int'((ph / 64'd32768) % 64'd256);
        tv  = (ph >= PHASE_MOD / 2) ? 255 - top : top;
        s   = (tv - 128) >>> v;
        return 8'(128 + s);
    endfunction

    task automatic check_val(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic compare_out(input int id, input exp_t e, input exp_t a);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL sb%0d at %0t: sound=%h busy=%b done=%b idx=%0d, required sound=%h busy=%b done=%b idx=%0d",
                     id, $time, a.sound, a.busy, a.done, a.idx, e.sound, e.busy, e.done, e.idx);
        end
    endtask

    task automatic pulse_start(input int id);
        @(negedge clk);
        if (id == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Asynchronous reset discards anything predicted for the cycle it interrupts.
    initial begin : reset_flush
        forever begin
            @(negedge rst_n);
            exp_q0.delete();
            exp_q1.delete();
            for (int id = 0; id < 2; id++) begin
                playing[id]  = 1'b0;
                kpos[id]     = 0;
                last_idx[id] = 2'd0;
            end
        end
    end

    // Reference model: position in the jingle timeline decides tone, gap and sample.
    initial begin : model
        exp_t e;
        int   t, seg, off, len, tc, nt;
        bit   st, sp;
        int   v;
        for (int id = 0; id < 2; id++) begin
            playing[id]  = 1'b0;
            kpos[id]     = 0;
            last_idx[id] = 2'd0;
        end
        forever begin
            @(posedge clk);
            for (int id = 0; id < 2; id++) begin
                tc  = (id == 0) ? TC0 : TC1;
                nt  = (id == 0) ? NT0 : NT1;
                len = tc + ((id == 0) ? GC0 : GC1);
                st  = (id == 0) ? start0 : start1;
                sp  = (id == 0) ? stop0 : stop1;
                v   = (id == 0) ? int'(vol0) : int'(vol1);
                e.sound = 8'h80;
                e.busy  = 1'b0;
                e.done  = 1'b0;
                e.idx   = last_idx[id];
                if (!rst_n) begin
                    playing[id] = 1'b0;
                    e.idx = 2'd0;
                end else if (sp) begin
                    playing[id] = 1'b0;
                end else if (!playing[id]) begin
                    if (st) begin
                        playing[id] = 1'b1;
                        kpos[id]    = 0;
                        e.idx       = 2'd0;
                        e.busy      = 1'b1;
                    end
                end else begin
                    t   = kpos[id];
                    kpos[id]++;
                    seg = t / len;
                    off = t % len;
                    e.busy = 1'b1;
                    e.idx  = 2'(seg);
                    if (off < tc - 1) begin
                        e.sound = shape(PHASE_START + longint'(off) * longint'(tone_inc(seg)), v);
                    end else if (off == tc - 1) begin
                        if (seg == nt - 1) begin
                            e.busy = 1'b0;
                            e.done = 1'b1;
                            playing[id] = 1'b0;
                        end
                    end else if (off == len - 1) begin
                        e.idx = 2'(seg + 1);
                    end
                end
                last_idx[id] = e.idx;
                if (id == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                compare_out(0, e, {sound0, busy0, done0, idx0});
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                compare_out(1, e, {sound1, busy1, done1, idx1});
            end
            if (done0 === 1'b1) n_done0++;
        end
    end

    initial begin : stimulus
        int d0, mx, mn;

        repeat (3) @(negedge clk);
        check_val("reset_sound0", int'(sound0), 8'h80);
        check_val("reset_busy0", int'(busy0), 0);
        check_val("reset_done0", int'(done0), 0);
        check_val("reset_idx0", int'(idx0), 0);
        check_val("reset_sound1", int'(sound1), 8'h80);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic jingle at full volume
        d0 = n_done0;
        pulse_start(0);
        repeat (JINGLE0 + 4) @(negedge clk);
        check_val("done_pulses", n_done0 - d0, 1);

        // Random volume, with ignored START requests mid-tone
        pulse_start(0);
        for (int i = 0; i < JINGLE0 + 4; i++) begin
            @(negedge clk);
            vol0   = 2'($urandom_range(0, 3));
            start0 = (i == 30 || i == 100) ? 1'b1 : 1'b0;
        end
        start0 = 1'b0;
        vol0   = 2'd0;

        // Abort in the first gap, then restart one cycle after STOP drops
        d0 = n_done0;
        pulse_start(0);
        repeat (66) @(negedge clk);
        stop0 = 1'b1;
        @(negedge clk);
        stop0 = 1'b0;
        check_val("abort_no_done", n_done0 - d0, 0);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (JINGLE0 + 4) @(negedge clk);

        // START and STOP together while idle
        @(negedge clk);
        start0 = 1'b1;
        stop0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        stop0  = 1'b0;
        repeat (5) @(negedge clk);

        // START in the cycle DONE is high
        pulse_start(0);
        repeat (JINGLE0) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (JINGLE0 + 5) @(negedge clk);

        // Random control traffic
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            vol0   = 2'($urandom_range(0, 3));
            start0 = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
            stop0  = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
        end
        start0 = 1'b0;
        stop0  = 1'b0;
        repeat (JINGLE0 + 5) @(negedge clk);

        // Long tone at VOL=2 then VOL=0: envelope limits over a full period
        vol1 = 2'd2;
        pulse_start(1);
        mx = 0;
        mn = 255;
        repeat (TC1 + 2) begin
            @(negedge clk);
            if (int'(sound1) > mx) mx = int'(sound1);
            if (int'(sound1) < mn) mn = int'(sound1);
        end
        check_val("vol2_peak", mx, 8'h9F);
        check_val("vol2_trough", mn, 8'h60);

        vol1 = 2'd0;
        pulse_start(1);
        mx = 0;
        mn = 255;
        repeat (TC1 + 2) begin
            @(negedge clk);
            if (int'(sound1) > mx) mx = int'(sound1);
            if (int'(sound1) < mn) mn = int'(sound1);
        end
        check_val("vol0_peak", mx, 8'hFF);
        check_val("vol0_trough", mn, 8'h00);

        // Asynchronous reset between clock edges while both instances play
        pulse_start(1);
        repeat (6000) @(negedge clk);
        pulse_start(0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("async_sound0", int'(sound0), 8'h80);
        check_val("async_busy0", int'(busy0), 0);
        check_val("async_sound1", int'(sound1), 8'h80);
        check_val("async_busy1", int'(busy1), 0);
        check_val("async_idx0", int'(idx0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
